// File: rtl/bg_pixel_fetcher_pkg.sv
// Shared constants, state type and palette helper for the background pixel fetcher.
package bg_pixel_fetcher_pkg;

    localparam int VRAM_AW    = 13;
    localparam int PUSH_WIDTH = 8;

    localparam logic [VRAM_AW-1:0] BG_MAP0_BASE     = 13'h1800;
    localparam logic [VRAM_AW-1:0] BG_MAP1_BASE     = 13'h1C00;
    localparam logic [VRAM_AW-1:0] TILE_SIGNED_BASE = 13'h1000;

    typedef logic [7:0] Pallete;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_MAP,
        FETCH_LO,
        FETCH_HI,
        PUSH
    } FetchState;

    function automatic logic [1:0] applyPallete(input Pallete pal, input logic [1:0] color);
        return pal[{color, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/bg_pixel_fifo.sv
// Pixel FIFO of 2-bit colour indices: one tile row (8 pixels) pushed at once, one pixel popped.
module bg_pixel_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [15:0]              push_data,
    input  logic                     pop,
    output logic [1:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    import bg_pixel_fetcher_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PUSH_INC = (AW + 1)'(PUSH_WIDTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Flush has priority so a line restart never sees stale pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < PUSH_WIDTH; i++) mem[wr_ptr + AW'(i)] <= push_data[2*i +: 2];
                wr_ptr <= wr_ptr + AW'(PUSH_WIDTH);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (push ? PUSH_INC : '0) - {{AW{1'b0}}, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/bg_pixel_fetcher.sv
// Background fetcher: walks the tile map, fetches tile rows into the pixel FIFO,
// applies fine-X discard and BGP, and streams one scanline of shaded pixels.
module bg_pixel_fetcher #(
    parameter int LINE_WIDTH = 160,
    parameter int FIFO_DEPTH = 16,
    parameter int VRAM_AW    = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_start,
    input  logic [7:0]         ly,
    input  logic [7:0]         scx,
    input  logic [7:0]         scy,
    input  logic [7:0]         lcdc,
    input  logic [7:0]         bgp,
    output logic               vram_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [1:0]         pix,
    output logic [7:0]         pix_x,
    output logic               line_done,
    output logic               busy
);
    import bg_pixel_fetcher_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]    LAST_X     = 8'(LINE_WIDTH - 1);
    localparam logic [9:0]    STOP_AT    = 10'(LINE_WIDTH + 8);
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(FIFO_DEPTH - PUSH_WIDTH);

    FetchState state_q, state_d;
    logic phase_q, phase_d;

    logic [7:0] ly_l, scx_l, scy_l, lcdc_l, bgp_l;
    logic [7:0] tile_q, lo_q, hi_q;
    logic [4:0] tile_col;
    logic [7:0] x;
    logic [2:0] discard;
    logic       busy_q, line_done_q;

    logic [7:0]         y;
    logic [4:0]         map_col;
    logic [VRAM_AW-1:0] map_addr, lo_addr;
    logic [CW-1:0]      count;
    logic               empty;
    logic [1:0]         head;
    logic [15:0]        push_data;
    logic               discard_pop, accept, last, pop, push, can_push;
    logic               cap_tile, cap_lo, cap_hi;
    logic [9:0]         sum_next;
    logic               lcdc_unused;

    assign lcdc_unused = ^{lcdc_l[7:5], lcdc_l[2:1]};

    assign y        = ly_l + scy_l;
    assign map_col  = scx_l[7:3] + tile_col;
    assign map_addr = (lcdc_l[3] ? VRAM_AW'(BG_MAP1_BASE) : VRAM_AW'(BG_MAP0_BASE))
                      + VRAM_AW'({y[7:3], map_col});
    assign lo_addr  = lcdc_l[4]
                      ? VRAM_AW'({tile_q, y[2:0], 1'b0})
                      : VRAM_AW'(TILE_SIGNED_BASE)
                        + {{(VRAM_AW-12){tile_q[7]}}, tile_q, 4'b0000}
                        + VRAM_AW'({y[2:0], 1'b0});

    assign discard_pop = busy_q && (discard != 3'd0) && !empty;
    assign pix_valid   = busy_q && (discard == 3'd0) && !empty && (x <= LAST_X);
    assign accept      = pix_valid && pix_ready;
    assign last        = accept && (x == LAST_X);
    assign pop         = (discard_pop || accept) && !line_start;
    assign can_push    = (count <= PUSH_LIMIT);

    // Occupancy after this cycle's push/pop decides whether enough pixels are queued for the line.
    assign sum_next = 10'(x) + 10'(accept) + 10'(count) + 10'(PUSH_WIDTH) - 10'(pop)
                      + 10'(discard) - 10'(discard_pop);

    assign pix       = pix_valid ? (lcdc_l[0] ? applyPallete(bgp_l, head) : 2'b00) : 2'b00;
    assign pix_x     = x;
    assign busy      = busy_q;
    assign line_done = line_done_q;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) push_data[2*i +: 2] = {hi_q[7-i], lo_q[7-i]};
    end

    bg_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (line_start || last),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Each fetch state strobes the read in phase 0 and captures the returned byte in phase 1.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        vram_rd   = 1'b0;
        vram_addr = '0;
        cap_tile  = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        push      = 1'b0;
        case (state_q)
            FETCH_MAP: vram_addr = map_addr;
            FETCH_LO:  vram_addr = lo_addr;
            FETCH_HI:  vram_addr = lo_addr + VRAM_AW'(1);
            default:   vram_addr = '0;
        endcase
        if (line_start) begin
            state_d = FETCH_MAP;
            phase_d = 1'b0;
        end else if (last) begin
            state_d = IDLE;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_MAP: begin
                    vram_rd = !phase_q;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        cap_tile = 1'b1;
                        state_d  = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    vram_rd = !phase_q;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        cap_lo  = 1'b1;
                        state_d = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    vram_rd = !phase_q;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        cap_hi  = 1'b1;
                        state_d = PUSH;
                    end
                end
                PUSH: begin
                    if (can_push) begin
                        push    = 1'b1;
                        state_d = (sum_next >= STOP_AT) ? IDLE : FETCH_MAP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ly_l        <= '0;
            scx_l       <= '0;
            scy_l       <= '0;
            lcdc_l      <= '0;
            bgp_l       <= '0;
            tile_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            tile_col    <= '0;
            x           <= '0;
            discard     <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else if (line_start) begin
            ly_l        <= ly;
            scx_l       <= scx;
            scy_l       <= scy;
            lcdc_l      <= lcdc;
            bgp_l       <= bgp;
            tile_col    <= '0;
            x           <= '0;
            discard     <= scx[2:0];
            busy_q      <= 1'b1;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= last;
            if (last) begin
                busy_q <= 1'b0;
                x      <= '0;
            end else if (accept) begin
                x <= x + 8'd1;
            end
            if (discard_pop) discard <= discard - 3'd1;
            if (cap_tile) tile_q <= vram_data;
            if (cap_lo) lo_q <= vram_data;
            if (cap_hi) hi_q <= vram_data;
            if (push) tile_col <= tile_col + 5'd1;
        end
    end

endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Self-checking bench: VRAM model, per-line pixel reference computed from scroll/tile rules, randomized backpressure.
module tb_bg_pixel_fetcher;

    localparam int LW = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  ly = '0, scx = '0, scy = '0, lcdc = '0, bgp = '0;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data = 8'h00;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [1:0]  pix;
    logic [7:0]  pix_x;
    logic        line_done;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;

    logic [7:0]  vram [8192];
    logic [12:0] rd_log [$];
    int          exp_line [LW];
    int          exp_x = 0;
    bit          line_active = 0, done_due = 0, prev_stall = 0;
    logic [1:0]  prev_pix = '0;
    logic [7:0]  prev_x = '0;

    bg_pixel_fetcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .ly         (ly),
        .scx        (scx),
        .scy        (scy),
        .lcdc       (lcdc),
        .bgp        (bgp),
        .vram_rd    (vram_rd),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix        (pix),
        .pix_x      (pix_x),
        .line_done  (line_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (vram_rd) vram_data <= vram[vram_addr];

    always @(posedge clk) if (rst_n && vram_rd) rd_log.push_back(vram_addr);

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    function automatic int modelPixel(int px, int lyv, int scxv, int scyv, int lcdcv, int bgpv);
        int sx, yy, maddr, t, taddr, lo, hi, b, c;
        sx    = (scxv + px) % 256;
        yy    = (lyv + scyv) % 256;
        maddr = (((lcdcv >> 3) & 1) != 0 ? 'h1C00 : 'h1800) + (yy / 8) * 32 + sx / 8;
        t     = vram[maddr];
        if (((lcdcv >> 4) & 1) != 0) begin
            taddr = t * 16 + (yy % 8) * 2;
        end else begin
            if (t > 127) t -= 256;
            taddr = (4096 + t * 16 + (yy % 8) * 2) & 8191;
        end
        lo = vram[taddr];
        hi = vram[(taddr + 1) & 8191];
        b  = 7 - sx % 8;
        c  = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
        return ((lcdcv & 1) != 0) ? ((bgpv >> (2 * c)) & 3) : 0;
    endfunction

    // Per-cycle comparison of handshake, stall stability, line_done/busy timing and pixel values.
    always @(negedge clk) begin
        bit acc;
        if (!rst_n) begin
            line_active = 0;
            done_due    = 0;
            prev_stall  = 0;
            exp_x       = 0;
        end else begin
            checkOutput("busy", int'(busy), int'(line_active));
            checkOutput("line_done", int'(line_done), int'(done_due));
            checkOutput("fifo_bound", int'(dut.u_fifo.count <= 16), 1);
            if (!line_active) checkOutput("idle_valid", int'(pix_valid), 0);
            if (prev_stall) begin
                checkOutput("stall_valid", int'(pix_valid), 1);
                checkOutput("stall_pix", int'(pix), int'(prev_pix));
                checkOutput("stall_x", int'(pix_x), int'(prev_x));
            end
            acc = pix_valid && pix_ready;
            done_due = 0;
            if (acc) begin
                checkOutput("pix_x", int'(pix_x), exp_x);
                if (exp_x < LW) checkOutput("pix", int'(pix), exp_line[exp_x]);
                exp_x++;
                if (exp_x == LW && !line_start) begin
                    done_due    = 1;
                    line_active = 0;
                end
            end
            prev_stall = pix_valid && !pix_ready && !line_start;
            prev_pix   = pix;
            prev_x     = pix_x;
            if (line_start) begin
                for (int i = 0; i < LW; i++)
                    exp_line[i] = modelPixel(i, ly, scx, scy, lcdc, bgp);
                exp_x       = 0;
                line_active = 1;
                done_due    = 0;
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                2:       pix_ready = (cyc % 3 == 0);
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic fillVram();
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] lyv, scxv, scyv, lcdcv, bgpv);
        @(posedge clk);
        #1;
        ly = lyv; scx = scxv; scy = scyv; lcdc = lcdcv; bgp = bgpv;
        line_start = 1'b1;
        rd_log.delete();
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic waitLineDone();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (line_done) seen = 1;
        end
        if (!seen) checkOutput("line_done_timeout", 0, 1);
    endtask

    function automatic int logAt(int i);
        return (rd_log.size() > i) ? int'(rd_log[i]) : -1;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_vram_rd"}, int'(vram_rd), 0);
        checkOutput({tag, "_vram_addr"}, int'(vram_addr), 0);
        checkOutput({tag, "_pix_valid"}, int'(pix_valid), 0);
        checkOutput({tag, "_pix"}, int'(pix), 0);
        checkOutput({tag, "_pix_x"}, int'(pix_x), 0);
        checkOutput({tag, "_line_done"}, int'(line_done), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        bit found;
        fillVram();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic unsigned tile fetch and decode order.
        ready_mode = 0;
        vram[13'h1800] = 8'h01;
        vram[13'h0010] = 8'hF0;
        vram[13'h0011] = 8'hCC;
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h91, 8'hE4);
        checkOutput("model_p0", exp_line[0], 3);
        checkOutput("model_p1", exp_line[1], 3);
        checkOutput("model_p2", exp_line[2], 1);
        checkOutput("model_p3", exp_line[3], 1);
        checkOutput("model_p4", exp_line[4], 2);
        checkOutput("model_p5", exp_line[5], 2);
        checkOutput("model_p6", exp_line[6], 0);
        checkOutput("model_p7", exp_line[7], 0);
        waitLineDone();
        checkOutput("t1_map_addr", logAt(0), 'h1800);
        checkOutput("t1_lo_addr", logAt(1), 'h0010);
        checkOutput("t1_hi_addr", logAt(2), 'h0011);

        // Signed tile data addressing.
        vram[13'h1800] = 8'h80;
        applyStimulus(8'h03, 8'h00, 8'h00, 8'h81, 8'hE4);
        waitLineDone();
        checkOutput("t2_lo_addr", logAt(1), 'h0806);
        checkOutput("t2_hi_addr", logAt(2), 'h0807);

        // Fine scroll discard with map 1 and scy wrap.
        ready_mode = 1;
        applyStimulus(8'h10, 8'h0B, 8'hF8, 8'h89, 8'h1B);
        waitLineDone();
        checkOutput("t3_map_addr", logAt(0), 'h1C21);

        // Map column wrap with 1-in-3 backpressure.
        ready_mode = 2;
        applyStimulus(8'h22, 8'hF8, 8'h00, 8'h91, 8'hD2);
        waitLineDone();
        checkOutput("t4_col0", logAt(0) & 31, 31);
        checkOutput("t4_col1", logAt(3) & 31, 0);
        checkOutput("t4_col2", logAt(6) & 31, 1);

        // Asynchronous reset during the low-byte fetch.
        ready_mode = 0;
        applyStimulus(8'h05, 8'h00, 8'h00, 8'h91, 8'hE4);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("lo_fetch_rd", int'(vram_rd), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midline_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Restart mid-line: no line_done for the aborted line.
        fillVram();
        applyStimulus(8'h40, 8'h13, 8'h07, 8'h99, 8'h6C);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 8'd50) found = 1;
        end
        if (!found) checkOutput("reach_x50_timeout", 0, 1);
        applyStimulus(8'h41, 8'h05, 8'h30, 8'h81, 8'h93);
        waitLineDone();

        // Background disabled gives all-zero pixels.
        ready_mode = 3;
        applyStimulus(8'h77, 8'h2A, 8'h11, 8'h90, 8'hFF);
        checkOutput("bg_off_model", exp_line[17], 0);
        waitLineDone();

        // Randomized lines with random backpressure patterns.
        for (int n = 0; n < 6; n++) begin
            fillVram();
            ready_mode = int'($urandom_range(0, 3));
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            waitLineDone();
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bg_pixel_fetcher.md
Name: bg_pixel_fetcher

Overview:
Background pixel pipeline stage for one scanline. It walks the background tile map, fetches tile data bytes from VRAM, and buffers decoded pixels in a small FIFO. It applies fine-X scroll discard and the BGP palette, then streams 160 shaded pixels per line over a valid/ready interface into the LCD line/frame writer, which packs them into the Line/Lcd output types.

Parameters:
LINE_WIDTH, 160, pixels emitted per line (LCD_LINEWIDTH)
FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥16)
VRAM_AW, 13, VRAM byte address width (offset from 0x8000)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
line_start  in  1  one-cycle pulse; latches inputs below, begins line
ly  in  8  current LcdY
scx  in  8  ScrollX
scy  in  8  ScrollY
lcdc  in  8  LcdControl raw; uses TileMapSelect(bit3), TileDataSelect(bit4), BackgroundDisplay(bit0)
bgp  in  8  BackgroundPallete raw
vram_rd  out  1  VRAM read strobe
vram_addr  out  VRAM_AW  VRAM read address
vram_data  in  8  read data, valid exactly one cycle after vram_rd
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix  out  2  shaded pixel
pix_x  out  8  column 0..159 of pix
line_done  out  1  one-cycle pulse after pixel 159 accepted
busy  out  1  line in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; all outputs 0 (vram_addr=0, pix_x=0).
- line_start: latch ly/scx/scy/lcdc/bgp; clear FIFO, tile_col=0, x=0, discard=scx[2:0]; enter FETCH_MAP; busy=1. line_start while busy aborts the current line with no line_done and restarts the same cycle.
- y = (ly+scy) mod 256; fine_y = y[2:0]; row = y[7:3].
- FETCH_MAP (2 cycles): cycle 1 vram_rd=1, addr = (lcdc[3]?0x1C00:0x1800) + row*32 + ((scx[7:3]+tile_col) mod 32); cycle 2 capture tile.
- FETCH_LO (2 cycles): addr = lcdc[4] ? tile*16+fine_y*2 : 0x1000 + signed(tile)*16 + fine_y*2 (13-bit wrap); capture lo.
- FETCH_HI (2 cycles): addr = lo addr+1; capture hi.
- PUSH: when FIFO free slots ≥8, write 8 pixels in one cycle; pixel i (i=0 leftmost) = {hi[7-i], lo[7-i]}; tile_col++; go to FETCH_MAP. Otherwise hold in PUSH.
- vram_rd is asserted only in the first cycle of each fetch state.
- Fetching stops, returning to IDLE, once pixels emitted + FIFO occupancy + discard ≥ LINE_WIDTH + 8.
- Output side: while discard>0 and FIFO non-empty, pop one per cycle, decrement discard, and keep pix_valid=0. Otherwise pix_valid = FIFO non-empty && x<LINE_WIDTH. pix = lcdc[0] ? bgp[2c+1:2c] : 2'b00, where c = the FIFO head. pix_x = x.
- Handshake: pop on pix_valid && pix_ready. pix/pix_x stay stable while pix_valid && !pix_ready. x++ on each pop.
- The pop at x=159: line_done=1 the next cycle; busy=0; FIFO flushed; state IDLE.
- FIFO push and pop in the same cycle: both happen, occupancy +7.
- tile_col wraps mod 32 via the map-column addition; scy+ly wraps mod 256.

Decomposition:
- video_types package additions: localparams BG_MAP0_BASE=0x1800, BG_MAP1_BASE=0x1C00, TILE_SIGNED_BASE=0x1000, VRAM_AW; typedef enum FetchState {IDLE, FETCH_MAP, FETCH_LO, FETCH_HI, PUSH}; function applyPallete(Pallete, bit[1:0]).
- Sub-module bg_pixel_fifo: FIFO_DEPTH×2-bit, 8-wide parallel push, 1-wide pop, count output.
- Top level holds the FSM, address generation and discard/column counters.

Test Plan:
- scx=0, scy=0, ly=0, lcdc=0x91, bgp=0xE4, map[0x1800]=0x01, tile1 bytes lo=0xF0, hi=0xCC at 0x0010/0x0011, pix_ready=1 -> first pixels 3,3,1,1,2,2,0,0. First vram_addr=0x1800, then 0x0010, then 0x0011. line_done after 160 accepted pixels.
- lcdc=0x81 (signed data), tile=0x80, ly=3 -> lo fetch addr=0x0806, hi=0x0807.
- scx=0x0B, scy=0xF8, ly=0x10, lcdc=0x89 -> first map addr=0x1C00+1*32+1=0x1C21. First 3 decoded pixels discarded. pix_x starts at 0.
- scx=0xF8 -> map column sequence 31,0,1… (wrap). Emitted pixel count is exactly 160.
- pix_ready toggled 1-in-3 -> pix/pix_x stable while stalled. No FIFO overflow (count≤16). No VRAM reads while PUSH waits.
- rst_n low mid-FETCH_LO -> outputs 0 immediately. Second line_start mid-line (x=50) -> no line_done, pix_x restarts at 0. lcdc[0]=0 -> all pix=0.
